// File: rtl/lisnoc_router_input_vc_pkg.sv
// Shared definitions for the LISNoC router input port: flit type codes, route
// selection constants and the per-lane route-stage state encoding.
package lisnoc_router_input_vc_pkg;

  localparam int FLIT_TYPE_W = 2;

  localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
  localparam logic [1:0] FLIT_HEADER  = 2'b01;
  localparam logic [1:0] FLIT_LAST    = 2'b10;
  localparam logic [1:0] FLIT_SINGLE  = 2'b11;

  localparam logic SELECT_NONE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_DROP   = 2'b10
  } lane_state_e;

endpackage

// File: rtl/lisnoc_router_input_vc_lane.sv
// One virtual-channel lane: link FIFO plus registered route stage with packet-level route locking.
// Optional macro LISNOC_INPUT_BYPASS_EN lets a flit skip an empty FIFO straight into the route stage.
module lisnoc_router_input_vc_lane
  import lisnoc_router_input_vc_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int TYPE_W    = 2,
  parameter int DEST_W    = 5,
  parameter int PORTS     = 5,
  parameter int DEPTH     = 4,
  parameter int NUM_DESTS = 1,
  parameter logic [PORTS*NUM_DESTS-1:0] LOOKUP = {(PORTS*NUM_DESTS){SELECT_NONE}},
  localparam int FW = DATA_W + TYPE_W,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_link_valid,
  input  logic [FW-1:0]    i_link_flit,
  output logic             o_link_ready,
  output logic [PORTS-1:0] o_switch_request,
  output logic [FW-1:0]    o_switch_flit,
  input  logic [PORTS-1:0] i_switch_read,
  output logic [CW-1:0]    o_fill,
  output logic             o_err_dest,
  output logic             o_err_orphan
);

  logic [FW-1:0]    r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  lane_state_e      r_state;
  logic             r_stage_valid;
  logic [FW-1:0]    r_stage_flit;
  logic [PORTS-1:0] r_route_dir;
  logic [PORTS-1:0] r_req;
  logic             r_err_dest;
  logic             r_err_orphan;

  logic             w_full;
  logic             w_consume;
  logic             w_stage_free;
  logic             w_bypass;
  logic             w_src_valid;
  logic [FW-1:0]    w_src_flit;
  logic             w_pop;
  logic             w_rd;
  logic             w_wr;
  logic [TYPE_W-1:0] w_type;
  logic [DEST_W-1:0] w_dest;
  logic [PORTS-1:0] w_dir;
  logic             w_is_route;
  logic             w_is_header;
  logic             w_is_last;

  function automatic logic [PORTS-1:0] f_lookup(input logic [DEST_W-1:0] dest);
    logic [PORTS-1:0] dir;
    dir = {PORTS{1'b0}};
    for (int d = 0; d < NUM_DESTS; d++) begin
      if (int'(dest) == d) dir = LOOKUP[(NUM_DESTS-1-d)*PORTS +: PORTS];
    end
    return dir;
  endfunction

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? {PW{1'b0}} : ptr + PW'(1);
  endfunction

  assign w_full       = (r_count == CW'(DEPTH));
  assign o_link_ready = ~w_full;
  assign w_consume    = r_stage_valid & (|(i_switch_read & r_req));
  assign w_stage_free = ~r_stage_valid | w_consume;

`ifdef LISNOC_INPUT_BYPASS_EN
  assign w_bypass = (r_count == {CW{1'b0}}) & i_link_valid & w_stage_free;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_src_valid = (r_count != {CW{1'b0}}) | w_bypass;
  assign w_src_flit  = w_bypass ? i_link_flit : r_mem[r_rptr];
  assign w_pop       = w_src_valid & w_stage_free;
  assign w_rd        = w_pop & ~w_bypass;
  assign w_wr        = i_link_valid & ~w_full & ~w_bypass;

  assign w_type      = w_src_flit[FW-1 -: TYPE_W];
  assign w_dest      = w_src_flit[DATA_W-1 -: DEST_W];
  assign w_dir       = f_lookup(w_dest);
  assign w_is_header = (w_type == TYPE_W'(FLIT_HEADER));
  assign w_is_last   = (w_type == TYPE_W'(FLIT_LAST));
  assign w_is_route  = w_is_header | (w_type == TYPE_W'(FLIT_SINGLE));

  // FIFO storage; contents are don't-care while the count says empty
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= i_link_flit;
  end

  // FIFO pointers, route-stage FSM and sticky error flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr        <= {PW{1'b0}};
      r_rptr        <= {PW{1'b0}};
      r_count       <= {CW{1'b0}};
      r_state       <= ST_IDLE;
      r_stage_valid <= 1'b0;
      r_stage_flit  <= {FW{1'b0}};
      r_route_dir   <= {PORTS{1'b0}};
      r_req         <= {PORTS{1'b0}};
      r_err_dest    <= 1'b0;
      r_err_orphan  <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= f_inc(r_wptr);
      if (w_rd) r_rptr <= f_inc(r_rptr);
      r_count <= r_count + {{(CW-1){1'b0}}, w_wr} - {{(CW-1){1'b0}}, w_rd};

      if (w_consume) begin
        r_stage_valid <= 1'b0;
        r_req         <= {PORTS{1'b0}};
      end

      // a load below overrides the clear above, giving back-to-back flits
      if (w_pop) begin
        case (r_state)
          ST_IDLE: begin
            if (w_is_route) begin
              if (w_dir != {PORTS{1'b0}}) begin
                r_stage_valid <= 1'b1;
                r_stage_flit  <= w_src_flit;
                r_req         <= w_dir;
                r_route_dir   <= w_dir;
                if (w_is_header) r_state <= ST_ACTIVE;
              end else begin
                r_err_dest <= 1'b1;
                if (w_is_header) r_state <= ST_DROP;
              end
            end else begin
              r_err_orphan <= 1'b1;
            end
          end
          ST_ACTIVE: begin
            r_stage_valid <= 1'b1;
            r_stage_flit  <= w_src_flit;
            r_req         <= r_route_dir;
            if (w_is_last) r_state <= ST_IDLE;
          end
          ST_DROP: begin
            if (w_is_last) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_switch_request = r_req;
  assign o_switch_flit    = r_stage_flit;
  assign o_fill           = r_count;
  assign o_err_dest       = r_err_dest;
  assign o_err_orphan     = r_err_orphan;

endmodule

// File: rtl/lisnoc_router_input_vc.sv
// LISNoC router input port: one independent lane per virtual channel, buses sliced per VC.
// Optional macro LISNOC_INPUT_BYPASS_EN enables the empty-FIFO bypass in every lane.
module lisnoc_router_input_vc
  import lisnoc_router_input_vc_pkg::*;
#(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int ph_dest_width   = 5,
  parameter int vchannels       = 2,
  parameter int ports           = 5,
  parameter int fifo_length     = 4,
  parameter int num_dests       = 1,
  parameter logic [ports*num_dests-1:0] lookup = {(ports*num_dests){SELECT_NONE}},
  localparam int flit_width = flit_data_width + flit_type_width,
  localparam int fill_width = $clog2(fifo_length + 1)
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [flit_width*vchannels-1:0] i_link_flit,
  input  logic [vchannels-1:0]            i_link_valid,
  output logic [vchannels-1:0]            o_link_ready,
  output logic [ports*vchannels-1:0]      o_switch_request,
  output logic [flit_width*vchannels-1:0] o_switch_flit,
  input  logic [ports*vchannels-1:0]      i_switch_read,
  output logic [vchannels*fill_width-1:0] o_fifo_fill,
  output logic [vchannels-1:0]            o_err_dest,
  output logic [vchannels-1:0]            o_err_orphan
);

  for (genvar v = 0; v < vchannels; v++) begin : g_lane
    lisnoc_router_input_vc_lane #(
      .DATA_W    (flit_data_width),
      .TYPE_W    (flit_type_width),
      .DEST_W    (ph_dest_width),
      .PORTS     (ports),
      .DEPTH     (fifo_length),
      .NUM_DESTS (num_dests),
      .LOOKUP    (lookup)
    ) u_lane (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_link_valid     (i_link_valid[v]),
      .i_link_flit      (i_link_flit[v*flit_width +: flit_width]),
      .o_link_ready     (o_link_ready[v]),
      .o_switch_request (o_switch_request[v*ports +: ports]),
      .o_switch_flit    (o_switch_flit[v*flit_width +: flit_width]),
      .i_switch_read    (i_switch_read[v*ports +: ports]),
      .o_fill           (o_fifo_fill[v*fill_width +: fill_width]),
      .o_err_dest       (o_err_dest[v]),
      .o_err_orphan     (o_err_orphan[v])
    );
  end

endmodule

// File: tb/tb_lisnoc_router_input_vc.sv
// Directed plus randomized bench for lisnoc_router_input_vc against a queue-based packet model.
module tb_lisnoc_router_input_vc;
  localparam int DW = 32, VC = 2, P = 5, DEPTH = 4, ND = 3, FW = 34, CW = 3;
  localparam logic [P*ND-1:0] LUT = {5'b00100, 5'b00010, 5'b00000};
  localparam logic [1:0] T_PAY = 2'b00, T_HDR = 2'b01, T_LAST = 2'b10, T_SGL = 2'b11;
  localparam logic [P*VC-1:0] SR_NONE = 10'b00000_00000;
  localparam logic [P*VC-1:0] SR_V0_S = 10'b00000_00100;
  localparam logic [P*VC-1:0] SR_V1_E = 10'b00010_00000;
  localparam logic [P*VC-1:0] SR_V1_S = 10'b00100_00000;

  typedef logic [FW-1:0] flit_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [FW*VC-1:0]     link_flit;
  logic [VC-1:0]        link_valid;
  logic [VC-1:0]        link_ready;
  logic [P*VC-1:0]      switch_request;
  logic [FW*VC-1:0]     switch_flit;
  logic [P*VC-1:0]      switch_read;
  logic [VC*CW-1:0]     fifo_fill;
  logic [VC-1:0]        err_dest;
  logic [VC-1:0]        err_orphan;

  always #5 clk = ~clk;

  lisnoc_router_input_vc #(
    .flit_data_width(DW), .flit_type_width(2), .ph_dest_width(5), .vchannels(VC),
    .ports(P), .fifo_length(DEPTH), .num_dests(ND), .lookup(LUT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_link_flit(link_flit), .i_link_valid(link_valid),
    .o_link_ready(link_ready), .o_switch_request(switch_request), .o_switch_flit(switch_flit),
    .i_switch_read(switch_read), .o_fifo_fill(fifo_fill), .o_err_dest(err_dest),
    .o_err_orphan(err_orphan)
  );

  // reference model: buffered flits per VC, the flit offered to the switch, packet mode
  flit_t          mq [VC][$];
  bit             m_sv [VC];
  flit_t          m_sf [VC];
  logic [P-1:0]   m_sd [VC];
  logic [P-1:0]   m_pd [VC];
  int             m_mode [VC];   // 0 between packets, 1 forwarding, 2 discarding
  bit             m_ed [VC];
  bit             m_eo [VC];

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [P-1:0] route_of(input int dest);
    if (dest == 0) return 5'b00100;
    else if (dest == 1) return 5'b00010;
    else return 5'b00000;
  endfunction

  function automatic flit_t mk(input logic [1:0] t, input int dest, input logic [31:0] pl);
    logic [4:0] d;
    d = dest[4:0];
    return {t, d, pl[26:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < VC; v++) begin
      mq[v].delete();
      m_sv[v] = 1'b0; m_sf[v] = '0; m_sd[v] = '0; m_pd[v] = '0;
      m_mode[v] = 0; m_ed[v] = 1'b0; m_eo[v] = 1'b0;
    end
  endtask

  task automatic process(input int v, input flit_t h);
    logic [1:0]   t;
    logic [P-1:0] dir;
    t   = h[FW-1 -: 2];
    dir = route_of(int'(h[DW-1 -: 5]));
    if (m_mode[v] == 0) begin
      if (t == T_HDR || t == T_SGL) begin
        if (dir != 5'b00000) begin
          m_sv[v] = 1'b1; m_sf[v] = h; m_sd[v] = dir; m_pd[v] = dir;
          if (t == T_HDR) m_mode[v] = 1;
        end else begin
          m_ed[v] = 1'b1;
          if (t == T_HDR) m_mode[v] = 2;
        end
      end else begin
        m_eo[v] = 1'b1;
      end
    end else if (m_mode[v] == 1) begin
      m_sv[v] = 1'b1; m_sf[v] = h; m_sd[v] = m_pd[v];
      if (t == T_LAST) m_mode[v] = 0;
    end else begin
      if (t == T_LAST) m_mode[v] = 0;
    end
  endtask

  task automatic model_step(input logic [VC-1:0] lv, input logic [FW*VC-1:0] lf,
                            input logic [P*VC-1:0] sr);
    for (int v = 0; v < VC; v++) begin
      flit_t f;
      flit_t h;
      bit ready, consume, free, have, bypassed;
      f        = lf[v*FW +: FW];
      ready    = (mq[v].size() < DEPTH);
      consume  = m_sv[v] && ((sr[v*P +: P] & m_sd[v]) != 5'b00000);
      free     = !m_sv[v] || consume;
      have     = 1'b0;
      bypassed = 1'b0;
      h        = '0;
      if (consume) m_sv[v] = 1'b0;
      if (mq[v].size() > 0) begin
        have = 1'b1;
        h = mq[v][0];
      end
`ifdef LISNOC_INPUT_BYPASS_EN
      else if (lv[v] && free) begin
        have = 1'b1; h = f; bypassed = 1'b1;
      end
`endif
      if (have && free) begin
        if (!bypassed) void'(mq[v].pop_front());
        process(v, h);
      end
      if (lv[v] && ready && !bypassed) mq[v].push_back(f);
    end
  endtask

  task automatic check_all();
    for (int v = 0; v < VC; v++) begin
      chk($sformatf("vc%0d_ready", v), 64'(link_ready[v]), 64'(mq[v].size() < DEPTH));
      chk($sformatf("vc%0d_request", v), 64'(switch_request[v*P +: P]), 64'(m_sv[v] ? m_sd[v] : 5'b00000));
      if (m_sv[v]) chk($sformatf("vc%0d_flit", v), 64'(switch_flit[v*FW +: FW]), 64'(m_sf[v]));
      chk($sformatf("vc%0d_fill", v), 64'(fifo_fill[v*CW +: CW]), 64'(mq[v].size()));
      chk($sformatf("vc%0d_err_dest", v), 64'(err_dest[v]), 64'(m_ed[v]));
      chk($sformatf("vc%0d_err_orphan", v), 64'(err_orphan[v]), 64'(m_eo[v]));
    end
  endtask

  task automatic step(input logic [VC-1:0] lv, input logic [FW*VC-1:0] lf, input logic [P*VC-1:0] sr);
    link_valid = lv; link_flit = lf; switch_read = sr;
    model_step(lv, lf, sr);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic send(input int v, input flit_t f, input logic [P*VC-1:0] sr);
    logic [VC-1:0]    lv;
    logic [FW*VC-1:0] lf;
    lv = '0; lf = '0;
    lv[v] = 1'b1;
    lf[v*FW +: FW] = f;
    step(lv, lf, sr);
  endtask

  task automatic idle(input logic [P*VC-1:0] sr);
    step('0, '0, sr);
  endtask

  task automatic do_reset();
    rst = 1'b1; link_valid = '0; link_flit = '0; switch_read = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_all();
    chk("rst_request", 64'(switch_request), 64'd0);
    chk("rst_flit", 64'(switch_flit[FW-1:0]), 64'd0);
    chk("rst_fill", 64'(fifo_fill), 64'd0);
    chk("rst_ready", 64'(link_ready), 64'd3);
  endtask

  initial begin
    int reqs;
    rst = 1'b1; link_valid = '0; link_flit = '0; switch_read = '0;
    model_reset();
    do_reset();

    // single-flit packet, request two cycles after the link write
    send(0, mk(T_SGL, 0, 32'h1234_5678), SR_V0_S);
    chk("t1_fill_n", 64'(fifo_fill[2:0]), 64'd1);
    chk("t1_req_n", 64'(switch_request[4:0]), 64'd0);
    idle(SR_V0_S);
    chk("t1_req_n2", 64'(switch_request[4:0]), 64'b00100);
    chk("t1_fill_n2", 64'(fifo_fill[2:0]), 64'd0);
    idle(SR_V0_S);
    chk("t1_req_done", 64'(switch_request[4:0]), 64'd0);

    // four-flit packet on VC1 streams at full rate
    reqs = 0;
    send(1, mk(T_HDR, 1, 32'hA), SR_V1_E);  if (switch_request[9:5] == 5'b00010) reqs++;
    send(1, mk(T_PAY, 3, 32'hB), SR_V1_E);  if (switch_request[9:5] == 5'b00010) reqs++;
    send(1, mk(T_PAY, 2, 32'hC), SR_V1_E);  if (switch_request[9:5] == 5'b00010) reqs++;
    send(1, mk(T_LAST, 0, 32'hD), SR_V1_E); if (switch_request[9:5] == 5'b00010) reqs++;
    for (int i = 0; i < 3; i++) begin
      idle(SR_V1_E);
      if (switch_request[9:5] == 5'b00010) reqs++;
    end
    chk("t2_req_count", 64'(reqs), 64'd4);
    chk("t2_req_end", 64'(switch_request[9:5]), 64'd0);

    // fill to capacity with the switch stalled
    send(0, mk(T_HDR, 0, 32'h10), SR_NONE);
    for (int i = 0; i < 4; i++) send(0, mk(T_PAY, 0, 32'h11 + 32'(i)), SR_NONE);
    chk("t3_full_fill", 64'(fifo_fill[2:0]), 64'd4);
    chk("t3_full_ready", 64'(link_ready[0]), 64'd0);
    send(0, mk(T_PAY, 0, 32'h99), SR_NONE);
    chk("t3_reject_fill", 64'(fifo_fill[2:0]), 64'd4);
    idle(SR_V0_S);
    chk("t3_after_read_ready", 64'(link_ready[0]), 64'd1);
    chk("t3_after_read_fill", 64'(fifo_fill[2:0]), 64'd3);
    send(0, mk(T_LAST, 0, 32'h20), SR_V0_S);
    for (int i = 0; i < 6; i++) idle(SR_V0_S);
    chk("t3_drained", 64'(fifo_fill[2:0]), 64'd0);

    // illegal destinations: out of range on VC0, unmapped lookup on VC1
    send(0, mk(T_HDR, 3, 32'h30), SR_V0_S);  chk("t4_noreq0", 64'(switch_request[4:0]), 64'd0);
    send(0, mk(T_PAY, 0, 32'h31), SR_V0_S);  chk("t4_noreq1", 64'(switch_request[4:0]), 64'd0);
    send(0, mk(T_LAST, 0, 32'h32), SR_V0_S); chk("t4_noreq2", 64'(switch_request[4:0]), 64'd0);
    for (int i = 0; i < 3; i++) begin
      idle(SR_V0_S);
      chk("t4_noreq_idle", 64'(switch_request[4:0]), 64'd0);
    end
    chk("t4_err_dest0", 64'(err_dest[0]), 64'd1);
    chk("t4_fill0", 64'(fifo_fill[2:0]), 64'd0);
    send(1, mk(T_SGL, 2, 32'h40), SR_NONE);
    idle(SR_NONE);
    chk("t4_err_dest1", 64'(err_dest[1]), 64'd1);
    chk("t4_err_dest0_sticky", 64'(err_dest[0]), 64'd1);

    // orphan payload dropped, next single still routed
    send(1, mk(T_PAY, 0, 32'h50), SR_V1_S);
    idle(SR_V1_S);
    chk("t5_orphan", 64'(err_orphan[1]), 64'd1);
    send(1, mk(T_SGL, 0, 32'h51), SR_V1_S);
    idle(SR_V1_S);
    chk("t5_single_req", 64'(switch_request[9:5]), 64'b00100);
    idle(SR_V1_S);

    // randomized traffic on both VCs
    for (int c = 0; c < 800; c++) begin
      logic [VC-1:0]    lv;
      logic [FW*VC-1:0] lf;
      logic [P*VC-1:0]  sr;
      for (int v = 0; v < VC; v++) begin
        lv[v] = ($urandom_range(0, 2) != 0);
        lf[v*FW +: FW] = mk(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom());
        sr[v*P +: P] = (m_sv[v] && ($urandom_range(0, 3) != 0)) ? m_sd[v] : 5'b00000;
      end
      step(lv, lf, sr);
    end

    // reset in the middle of a packet
    send(0, mk(T_HDR, 0, 32'h60), SR_NONE);
    send(0, mk(T_PAY, 0, 32'h61), SR_NONE);
    send(0, mk(T_PAY, 0, 32'h62), SR_NONE);
    do_reset();
    send(0, mk(T_SGL, 0, 32'h70), SR_NONE);
`ifdef LISNOC_INPUT_BYPASS_EN
    chk("t6_bypass_req", 64'(switch_request[4:0]), 64'b00100);
    chk("t6_bypass_fill", 64'(fifo_fill[2:0]), 64'd0);
`else
    chk("t6_fifo_req", 64'(switch_request[4:0]), 64'd0);
    chk("t6_fifo_fill", 64'(fifo_fill[2:0]), 64'd1);
`endif
    for (int i = 0; i < 3; i++) idle(SR_V0_S);
    chk("t6_final_req", 64'(switch_request), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
